// File: rtl/enemy_fire_sched.sv
// Round-robin scheduler that shares the one enemy missile among N enemies:
// a level-dependent cooldown, then a grant to the next living enemy after the last shooter.
//
// state | meaning
// IDLE  | wave inactive or nobody alive; waiting for enable with a living enemy
// COOL  | cooldown running, cd_cnt counts down to zero
// PICK  | one-cycle round-robin scan for the next living enemy after ptr
// REQ   | fire_req held for fire_sel until acked or that enemy dies
// WAIT  | shot accepted, waiting for the missile to leave the screen
module enemy_fire_sched #(
  parameter int              N       = 4,
  parameter int              CD_W    = 24,
  parameter logic [CD_W-1:0] BASE_CD = CD_W'(4000000),
  parameter logic [CD_W-1:0] STEP_CD = CD_W'(250000),
  parameter logic [CD_W-1:0] MIN_CD  = CD_W'(500000)
) (
  input  logic         pclk_i,
  input  logic         rst_ni,
  input  logic         enable_i,
  input  logic [3:0]   level_i,
  input  logic [N-1:0] alive_i,
  input  logic         fire_busy_i,
  input  logic         fire_ack_i,
  output logic         fire_req_o,
  output logic [3:0]   fire_sel_o,
  output logic         wave_clear_o,
  output logic [7:0]   shot_cnt_o
);

  localparam int PW = CD_W + 4;

  typedef enum logic [2:0] {S_IDLE, S_COOL, S_PICK, S_REQ, S_WAIT} state_e;

  state_e          state_q, state_d;
  logic [CD_W-1:0] cd_cnt_q, cd_cnt_d;
  logic [3:0]      ptr_q, ptr_d;
  logic [3:0]      sel_q, sel_d;
  logic [7:0]      shot_q, shot_d;
  logic            req_q, req_d;
  logic            clear_q, clear_d;

  logic [PW-1:0]   cd_prod;
  logic [CD_W-1:0] cd_val;
  logic [15:0]     alive_x;
  logic [4:0]      idx;
  logic [3:0]      cand;
  logic            found;

  assign alive_x = 16'(alive_i);
  assign cd_prod = PW'(level_i) * PW'(STEP_CD);

  // Clamp before subtracting so the cooldown never underflows below the floor.
  always_comb begin
    if (cd_prod > PW'(BASE_CD - MIN_CD)) cd_val = MIN_CD;
    else                                 cd_val = BASE_CD - cd_prod[CD_W-1:0];
  end

  always_comb begin
    found = 1'b0;
    cand  = '0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = 5'(ptr_q) + 5'(k);
      if (idx >= 5'(N)) idx = idx - 5'(N);
      if (!found && alive_x[idx[3:0]]) begin
        found = 1'b1;
        cand  = idx[3:0];
      end
    end
  end

  always_ff @(posedge pclk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!enable_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (|alive_i) state_d = S_COOL;
        S_COOL: if (cd_cnt_q == '0) state_d = S_PICK;
        S_PICK: state_d = found ? S_REQ : S_IDLE;
        S_REQ: begin
          if (fire_ack_i)              state_d = S_WAIT;
          else if (!alive_x[sel_q])    state_d = S_PICK;
        end
        S_WAIT: if (!fire_busy_i) state_d = S_COOL;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cd_cnt_d = cd_cnt_q;
    ptr_d    = ptr_q;
    sel_d    = sel_q;
    shot_d   = shot_q;
    req_d    = (state_d == S_REQ);
    clear_d  = enable_i && (alive_i == '0);
    if (state_d == S_COOL && state_q != S_COOL)
      cd_cnt_d = cd_val - CD_W'(1);
    else if (state_q == S_COOL && cd_cnt_q != '0)
      cd_cnt_d = cd_cnt_q - CD_W'(1);
    if (state_q == S_PICK && state_d == S_REQ)
      sel_d = cand;
    if (state_q == S_REQ && state_d == S_WAIT) begin
      ptr_d  = sel_q;
      shot_d = shot_q + 8'd1;
    end
  end

  always_ff @(posedge pclk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cd_cnt_q <= '0;
      ptr_q    <= 4'(N - 1);
      sel_q    <= '0;
      shot_q   <= '0;
      req_q    <= 1'b0;
      clear_q  <= 1'b0;
    end else begin
      cd_cnt_q <= cd_cnt_d;
      ptr_q    <= ptr_d;
      sel_q    <= sel_d;
      shot_q   <= shot_d;
      req_q    <= req_d;
      clear_q  <= clear_d;
    end
  end

  assign fire_req_o   = req_q;
  assign fire_sel_o   = sel_q;
  assign wave_clear_o = clear_q;
  assign shot_cnt_o   = shot_q;

endmodule
